// File: rtl/cacheline_adapter.sv
// cacheline_adapter: bridges one 256-bit cache line request to a fixed 4-beat, 64-bit memory burst.
// Define CACHELINE_ADAPTER_PROTOCOL_CHECK_EN to build the sticky protocol-error monitor driving err.
module cacheline_adapter #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pmem_address,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [s_line-1:0]  pmem_wdata,
  output logic [s_line-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic [31:0]        mem_address,
  output logic               mem_read,
  output logic               mem_write,
  output logic [s_burst-1:0] mem_wdata,
  input  logic [s_burst-1:0] mem_rdata,
  input  logic               mem_resp,
  output logic               err
);

  localparam int num_beats = s_line / s_burst;
  localparam int cnt_w     = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam logic [cnt_w-1:0] c_last_beat = cnt_w'(num_beats - 1);
  localparam logic [cnt_w-1:0] c_one       = cnt_w'(1);
  localparam logic [cnt_w-1:0] c_zero      = cnt_w'(0);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  state_e             r_state;
  state_e             w_next_state;
  logic [cnt_w-1:0]   r_cnt;
  logic [31:0]        r_addr;
  logic [s_line-1:0]  r_line;
  logic [s_line-1:0]  r_rdata;
  logic [31:0]        w_aligned_addr;
  logic               w_last_ack;
  logic               w_mem_read;
  logic               w_mem_write;
  logic               w_pmem_resp;
  logic               w_unused;

  assign w_aligned_addr = {pmem_address[31:s_offset], {s_offset{1'b0}}};
  assign w_last_ack     = mem_resp && (r_cnt == c_last_beat);
  assign w_unused       = &{1'b0, pmem_address[s_offset-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (pmem_write) begin
          w_next_state = ST_WR_BURST;
        end else if (pmem_read) begin
          w_next_state = ST_RD_BURST;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RD_BURST: begin
        if (w_last_ack) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_RD_BURST;
        end
      end
      ST_WR_BURST: begin
        if (w_last_ack) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_WR_BURST;
        end
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_pmem_resp = 1'b0;
    case (r_state)
      ST_IDLE:     w_pmem_resp = 1'b0;
      ST_RD_BURST: w_mem_read  = 1'b1;
      ST_WR_BURST: w_mem_write = 1'b1;
      ST_DONE:     w_pmem_resp = 1'b1;
      default:     w_pmem_resp = 1'b0;
    endcase
  end

  // Request capture, beat counting and read-line assembly; stalls (no mem_resp) hold everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= c_zero;
      r_addr  <= 32'h0000_0000;
      r_line  <= {s_line{1'b0}};
      r_rdata <= {s_line{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (pmem_write) begin
            r_addr <= w_aligned_addr;
            r_line <= pmem_wdata;
            r_cnt  <= c_zero;
          end else if (pmem_read) begin
            r_addr <= w_aligned_addr;
            r_cnt  <= c_zero;
          end
        end
        ST_RD_BURST: begin
          if (mem_resp) begin
            r_rdata[r_cnt*s_burst +: s_burst] <= mem_rdata;
            r_cnt <= w_last_ack ? c_zero : (r_cnt + c_one);
          end
        end
        ST_WR_BURST: begin
          if (mem_resp) begin
            r_cnt <= w_last_ack ? c_zero : (r_cnt + c_one);
          end
        end
        default: r_cnt <= c_zero;
      endcase
    end
  end

  assign mem_address = r_addr;
  assign mem_read    = w_mem_read;
  assign mem_write   = w_mem_write;
  assign pmem_resp   = w_pmem_resp;
  assign pmem_rdata  = r_rdata;
  assign mem_wdata   = w_mem_write ? r_line[r_cnt*s_burst +: s_burst] : {s_burst{1'b0}};

`ifdef CACHELINE_ADAPTER_PROTOCOL_CHECK_EN
  logic r_err;
  logic w_proto_viol;

  // A burst in flight must see a stable line address from the still-asserted request.
  always_comb begin
    w_proto_viol = 1'b0;
    case (r_state)
      ST_IDLE:     w_proto_viol = (pmem_read && pmem_write) || mem_resp;
      ST_RD_BURST,
      ST_WR_BURST: w_proto_viol = (pmem_read || pmem_write) &&
                                  (pmem_address[31:s_offset] != r_addr[31:s_offset]);
      ST_DONE:     w_proto_viol = mem_resp;
      default:     w_proto_viol = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_proto_viol;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
Responder on the cache's physical-memory port. Accepts one 256-bit line read or write from the cache datapath/control at a time. Converts each request into a fixed 4-beat, 64-bit burst on the main-memory bus, and returns a single-cycle completion to the cache. Sits between the cache's pmem interface and burst memory.

Parameters:
s_line, 256, cacheline width in bits
s_burst, 64, memory beat width in bits
s_offset, 5, line offset bits; memory address forced line-aligned
num_beats, s_line/s_burst (4), beats per burst; derived, must be integer

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
pmem_address  in  32  line address from cache
pmem_read  in  1  line read request, held until pmem_resp
pmem_write  in  1  line write request, held until pmem_resp
pmem_wdata  in  s_line  line to write, valid while pmem_write high
pmem_rdata  out  s_line  assembled read line
pmem_resp  out  1  one-cycle completion pulse to cache
mem_address  out  32  burst base address, {pmem_address[31:s_offset], 0}
mem_read  out  1  burst read request, held through all beats
mem_write  out  1  burst write request, held through all beats
mem_wdata  out  s_burst  current write beat
mem_rdata  in  s_burst  current read beat, valid when mem_resp high
mem_resp  in  1  beat accepted/returned this cycle
err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state IDLE, beat counter 0, latched address/line 0, pmem_rdata 0. pmem_resp, mem_read, mem_write, err all 0. mem_address 0, mem_wdata 0. A request in flight is abandoned; no completion issues.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - pmem_write high -> latch aligned address and pmem_wdata, counter=0, go WR_BURST.
  - else pmem_read high -> latch aligned address, counter=0, go RD_BURST.
  - write has priority if both are high.
  - mem_resp is ignored in IDLE.
- RD_BURST:
  - mem_read=1, mem_address=latched address.
  - Each cycle with mem_resp=1: pmem_rdata[s_burst*cnt +: s_burst] <= mem_rdata, cnt++.
  - On the beat with cnt==num_beats-1 -> DONE, cnt=0.
  - Cycles without mem_resp are stalls: nothing changes.
- WR_BURST:
  - mem_write=1, mem_wdata=latched_line[s_burst*cnt +: s_burst] (combinational from counter).
  - Each mem_resp advances cnt. Last beat -> DONE.
  - Beat 0 carries line bits [63:0].
- DONE:
  - pmem_resp=1 for exactly this one cycle; mem_read=mem_write=0; unconditional -> IDLE.
  - pmem_rdata is valid in DONE and holds until the next read burst writes it.
  - The cache must drop pmem_read/pmem_write in the cycle after pmem_resp. A request still high in IDLE starts a new transaction.
- Latency with zero-stall memory: request seen at edge 0; beats on cycles 1–4; pmem_resp in cycle 5. Each mem_resp stall adds 1 cycle.
- pmem_address/pmem_wdata changes after acceptance have no effect (latched copies are used).
- Counter width is clog2(num_beats); it wraps to 0 only via the DONE transition.

Optional Feature:
Macro CACHELINE_ADAPTER_PROTOCOL_CHECK_EN.
- Defined: err is set sticky, cleared only by rst, on any of:
  - pmem_read && pmem_write in IDLE;
  - mem_resp=1 in IDLE or DONE;
  - pmem_address[31:s_offset] differs from the latched value while in RD_BURST/WR_BURST and a request is high.
- Undefined: err is tied to 0 and no checking logic is built.
- Functional behaviour is otherwise identical in both builds.

Test Plan:
- Read, no stalls: pmem_address=0x0000_1234, pmem_read=1; mem_rdata beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive mem_resp -> mem_address=0x0000_1220; pmem_resp in cycle 5; pmem_rdata={0x44..,0x33..,0x22..,0x11..}.
- Write with stalls: pmem_wdata=256'h0123..CDEF, pmem_write=1; mem_resp on cycles 2,3,6,7 -> mem_wdata shows beats 0..3 in order, each held until acked; mem_write held through cycle 7; pmem_resp in cycle 8.
- Read and write both high in IDLE -> write burst runs (mem_write=1, mem_read=0); err=1 only in a CHECK_EN build.
- Async reset asserted mid-read after 2 beats -> all outputs 0 immediately; no pmem_resp. A new read after reset completes normally with all 4 fresh beats.
- Back-to-back: cache drops read the cycle after pmem_resp, then raises write 1 cycle later -> write accepted from IDLE; pmem_rdata retains the previous read line throughout the write.
- Spurious mem_resp in IDLE -> no state change, pmem_rdata unchanged; err=1 in a CHECK_EN build, 0 otherwise.
